pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_slot.sv | 24 ++
 rtl/pipe_stage_reg.sv | 127 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline boundary registers: stage occupancy
// states and the default control bubble presented when no payload is valid.
package pipe_pkg;

  // Occupancy of a two-slot skid stage; the encoding equals the held count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // Bubble control word: all control bits low means no RegWrite, no MemWrite,
  // no MemRead, so a bubble has no architectural side effect downstream.
  localparam logic [15:0] BUBBLE_CTRL_DEFAULT = 16'h0000;

endpackage

// File: rtl/pipe_slot.sv
// Load-enabled payload register with asynchronous clear, used for both the
// main (output-driving) slot and the skid slot of a pipeline stage.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture the payload on load; hold otherwise.
  // NOTE: the storage is reset (not left uninitialised) because the stage's
  // reset output values, including out_data/out_rd, are defined as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register (IF/ID, ID/EX, EX/MEM) with a one-entry skid
// buffer. in_ready is registered so it never depends combinationally on
// out_ready, which breaks the ready path between stages. flush kills
// everything held and has priority over any same-cycle accept or pop.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                CTRL_W      = 16,
  parameter int                RD_W        = 6,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(BUBBLE_CTRL_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RD_W-1:0]   out_rd,
  output logic [1:0]        count
);

  localparam int PAY_W = DATA_W + CTRL_W + RD_W;

  stage_state_e      state_q, state_d;
  logic              in_ready_q;
  logic              accept, pop;
  logic              main_load, skid_load, main_from_skid;
  logic [PAY_W-1:0]  in_pay, main_d, main_q, skid_q;

  assign in_pay   = {in_data, in_ctrl, in_rd};
  assign in_ready = in_ready_q;
  assign accept   = in_valid & in_ready_q;
  assign pop      = out_valid & out_ready;
  assign main_d   = main_from_skid ? skid_q : in_pay;

  // State register and registered ready; ready is low in reset and rises on
  // the first edge after release, so no accept can happen on that edge.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // Next-state and slot-load decisions; flush overrides accept and pop.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (pop && !accept) begin
            state_d = EMPTY;
          end else if (accept && pop) begin
            main_load = 1'b1;
          end
        end
        FULL: begin
          if (pop) begin
            state_d        = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Outputs: valid/count from the state, payload from main, bubble control
  // whenever nothing valid is presented.
  always_comb begin
    out_valid = (state_q != EMPTY);
    unique case (state_q)
      ONE:     count = 2'd1;
      FULL:    count = 2'd2;
      default: count = 2'd0;
    endcase
    out_data = main_q[PAY_W-1 -: DATA_W];
    out_rd   = main_q[RD_W-1:0];
    out_ctrl = out_valid ? main_q[RD_W +: CTRL_W] : BUBBLE_CTRL;
  end

  pipe_slot #(.W(PAY_W)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_slot #(.W(PAY_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .d     (in_pay),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios followed by a long random run,
// all compared against a queue-based reference of the stage's contents.
module tb_pipe_stage_reg;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 16;
  localparam int RD_W   = 6;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic [RD_W-1:0]   rd;
  } payload_t;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic [RD_W-1:0]   in_rd;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [RD_W-1:0]   out_rd;
  logic [1:0]        count;

  pipe_stage_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .RD_W   (RD_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_rd     (in_rd),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .out_rd    (out_rd),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the stage is a FIFO of at most two payloads; ready is known
  // only from the previous cycle's occupancy and is low right after reset.
  payload_t model_q[$];
  logic     m_ready;
  int       n_checks = 0;
  int       n_pass   = 0;
  int       pops_seen = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic [RD_W-1:0] r, input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    in_rd     = r;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic check_outputs();
    check("count", 64'(count), 64'(model_q.size()));
    check("in_ready", 64'(in_ready), 64'(m_ready));
    check("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      check("out_data", out_data, model_q[0].data);
      check("out_ctrl", 64'(out_ctrl), 64'(model_q[0].ctrl));
      check("out_rd", 64'(out_rd), 64'(model_q[0].rd));
    end else begin
      check("bubble_ctrl", 64'(out_ctrl), 64'(0));
    end
  endtask

  // One clock: decide the model's accept/pop from pre-edge inputs, advance
  // through the edge, update the model and compare.
  task automatic step();
    payload_t p;
    logic     acc, pp;
    acc    = in_valid && m_ready;
    pp     = (model_q.size() != 0) && out_ready;
    p.data = in_data;
    p.ctrl = in_ctrl;
    p.rd   = in_rd;
    if (out_valid && out_ready) pops_seen++;
    @(posedge clk);
    #1;
    if (flush) begin
      model_q.delete();
    end else begin
      if (pp) void'(model_q.pop_front());
      if (acc) model_q.push_back(p);
    end
    m_ready = (model_q.size() < 2);
    check_outputs();
  endtask

  initial begin
    rst_n   = 1'b0;
    m_ready = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);

    // Reset state.
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_out_data", out_data, 64'(0));
    check("rst_out_rd", 64'(out_rd), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First edge after release: in_valid held but no accept may occur.
    drive(1'b1, 64'hDEAD, 16'h0001, 6'd1, 1'b1, 1'b0);
    check("post_rst_in_ready_low", 64'(in_ready), 64'(0));
    step();
    check("post_rst_no_accept", 64'(count), 64'(0));
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    step();

    // Streaming with out_ready held high.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'(32'h100 + 4 * i), 16'h0011, 6'(i + 2), 1'b1, 1'b0);
      step();
      check("stream_data", out_data, 64'(32'h100 + 4 * i));
      check("stream_count", 64'(count), 64'(1));
      check("stream_ready", 64'(in_ready), 64'(1));
    end
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    step();

    // Stall: fill both slots, then drain in order.
    drive(1'b1, 64'hA, 16'h00A0, 6'd10, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'hB, 16'h00B0, 6'd11, 1'b0, 1'b0);
    step();
    check("stall_count", 64'(count), 64'(2));
    check("stall_ready", 64'(in_ready), 64'(0));
    check("stall_hold_a", out_data, 64'hA);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    step();
    check("stall_stable_a", out_data, 64'hA);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    step();
    check("drain_b", out_data, 64'hB);
    step();
    check("drain_empty", 64'(out_valid), 64'(0));

    // Flush while full with a competing input payload.
    drive(1'b1, 64'hA, 16'h00A0, 6'd10, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'hB, 16'h00B0, 6'd11, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'hC, 16'h00C0, 6'd12, 1'b1, 1'b1);
    step();
    check("flush_valid", 64'(out_valid), 64'(0));
    check("flush_bubble", 64'(out_ctrl), 64'(0));
    check("flush_count", 64'(count), 64'(0));
    check("flush_ready", 64'(in_ready), 64'(1));
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    repeat (2) step();
    check("flush_c_dropped", 64'(out_valid), 64'(0));

    // Simultaneous accept and pop while holding one payload.
    drive(1'b1, 64'h1, 16'h0101, 6'd1, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h2, 16'h0202, 6'd2, 1'b1, 1'b0);
    step();
    check("accpop_data", out_data, 64'h2);
    check("accpop_count", 64'(count), 64'(1));
    drive(1'b1, 64'h3, 16'h0303, 6'd3, 1'b0, 1'b0);
    step();
    check("pre_arst_full", 64'(count), 64'(2));

    // Asynchronous reset between edges while full.
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'(0));
    check("arst_count", 64'(count), 64'(0));
    check("arst_ready", 64'(in_ready), 64'(0));
    check("arst_ctrl", 64'(out_ctrl), 64'(0));
    check("arst_data", out_data, 64'(0));
    model_q.delete();
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 64'h77, 16'h0777, 6'd7, 1'b1, 1'b0);
    check("arst_release_ready_low", 64'(in_ready), 64'(0));
    step();
    check("arst_first_edge_ready", 64'(in_ready), 64'(1));
    check("arst_no_partial", 64'(out_valid), 64'(0));

    // Random scoreboard run.
    pops_seen = 0;
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 16'($urandom), 6'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
      step();
    end
    check("random_traffic_flowed", 64'(pops_seen > 2000), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
